// File: rtl/pipe_credit_arb.sv
// ----------------------------------------------------------------------------
// pipe_credit_arb
//
// Round-robin arbiter feeding a fixed-latency register pipeline and a
// credit-protected output FIFO. A requester is granted only while a free
// credit exists, so every beat in the pipeline is guaranteed a FIFO slot and
// the pipeline never needs to stall.
//
// Ports
//   clk        sole clock, all state on the rising edge
//   rst        synchronous, active-high reset
//   in_data    requester r data at bits [r*WIDTH +: WIDTH]
//   in_valid   per-requester beat valid
//   in_ready   per-requester accept (one-hot or zero, combinational)
//   out_data   data of the beat at the FIFO head
//   out_id     requester index of the head beat
//   out_valid  head beat valid
//   out_ready  consumer accept
//   credits    number of free credits (FIFO slots not yet promised)
//   busy       high while any beat is in the pipeline or the FIFO
// ----------------------------------------------------------------------------
module pipe_credit_arb #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 512,
  parameter int NUM_PIPES = 2,
  parameter int CREDITS   = 8,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(CREDITS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_valid,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         credits,
  output logic                     busy
);

  localparam int PTR_W = $clog2(CREDITS);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
  } beat_t;

  // Arbiter / credit state
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  // Blocks grants in the first cycle after reset is released.
  logic             init_q, init_d;

  // FIFO state
  beat_t            mem_q [CREDITS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic             can_grant;
  logic             grant;
  logic             pop;
  beat_t            grant_beat;
  logic             wr_en;
  beat_t            wr_beat;
  logic             pipe_busy;

  // --------------------------------------------------------------------------
  // Round-robin search starting one past the last granted requester.
  // --------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // A grant consumes a credit in the same cycle; a pop's credit only becomes
  // usable next cycle because the decision looks at credits_q, never at pop.
  assign can_grant = !rst && !init_q && (credits_q != '0);
  assign grant     = can_grant && win_found;
  assign in_ready  = grant ? (NUM_REQ'(1) << win_id) : '0;

  assign grant_beat.id   = win_id;
  assign grant_beat.data = in_data[int'(win_id)*WIDTH +: WIDTH];

  // --------------------------------------------------------------------------
  // Fixed-latency pipeline: no stall path, since a credit was taken at grant.
  // --------------------------------------------------------------------------
  if (NUM_PIPES > 0) begin : g_pipe
    logic  [NUM_PIPES-1:0] vld_q, vld_d;
    beat_t [NUM_PIPES-1:0] beat_q, beat_d;

    always_comb begin
      vld_d[0]  = grant;
      beat_d[0] = grant_beat;
      for (int i = 1; i < NUM_PIPES; i++) begin
        vld_d[i]  = vld_q[i-1];
        beat_d[i] = beat_q[i-1];
      end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
      // Payload is qualified by vld_q, so it needs no reset.
      beat_q <= beat_d;
    end

    assign wr_en     = vld_q[NUM_PIPES-1];
    assign wr_beat   = beat_q[NUM_PIPES-1];
    assign pipe_busy = |vld_q;
  end else begin : g_no_pipe
    assign wr_en     = grant;
    assign wr_beat   = grant_beat;
    assign pipe_busy = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Output FIFO. The head is read straight from registered storage, so
  // out_valid rises the cycle after the write and the head is stable until
  // popped.
  // --------------------------------------------------------------------------
  assign out_valid = !rst && (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q].data;
  assign out_id    = mem_q[rd_ptr_q].id;
  assign credits   = credits_q;
  assign busy      = !rst && (pipe_busy || (count_q != '0));

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    credits_d    = credits_q;
    last_grant_d = last_grant_q;
    init_d       = 1'b0;

    // Pointers wrap naturally since CREDITS is a power of two.
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case ({grant, pop})
      2'b10:   credits_d = credits_q - CNT_W'(1);
      2'b01:   credits_d = credits_q + CNT_W'(1);
      default: credits_d = credits_q;
    endcase

    if (grant) last_grant_d = win_id;
  end

  // NOTE: FIFO storage is deliberately left out of reset; emptiness is
  // tracked by count_q, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      credits_q    <= CNT_W'(CREDITS);
      init_q       <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      credits_q    <= credits_d;
      init_q       <= init_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_credit_arb.sv
// ----------------------------------------------------------------------------
// tb_pipe_credit_arb
//
// Two instances run side by side: the default build (NUM_PIPES=2) and a
// NUM_PIPES=0 build. Each instance has its own stimulus, a reference model
// that derives grants from the round-robin/credit rules, and a scoreboard
// queue of expected beats (with the cycle each beat may first appear) that a
// separate monitor process drains as the DUT presents output.
// ----------------------------------------------------------------------------
module tb_pipe_credit_arb;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 512;
  localparam int CREDITS = 8;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(CREDITS) + 1;

  typedef enum int {
    P_RESET, P_IDLE, P_SINGLE, P_DRAIN, P_RR, P_BP_FILL, P_BP_ONE,
    P_BP_HOLD, P_BOTH, P_RAND, P_MID_FILL
  } phase_e;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
    int               gcyc;
    int               avail;
  } exp_t;

  logic   clk   = 1'b0;
  logic   rst   = 1'b1;
  phase_e phase = P_RESET;
  int     tests = 0;
  int     fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int NP = (k == 0) ? 2 : 0;

    logic [NUM_REQ*WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]       in_valid;
    logic [NUM_REQ-1:0]       in_ready;
    logic [WIDTH-1:0]         out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         credits;
    logic                     busy;

    pipe_credit_arb #(
      .NUM_REQ  (NUM_REQ),
      .WIDTH    (WIDTH),
      .NUM_PIPES(NP),
      .CREDITS  (CREDITS)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_id   (out_id),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .credits  (credits),
      .busy     (busy)
    );

    exp_t sb[$];
    int   cyc         = 0;
    int   last_grant  = NUM_REQ - 1;
    bit   init_blk    = 1'b0;
    int   grants      = 0;
    int   single_left = 1;

    // Stimulus + reference model: decides which requester must be granted.
    initial begin : drv
      string              pfx;
      phase_e             prev_phase;
      int                 outst;
      int                 win;
      bit                 blocked;
      logic [NUM_REQ-1:0] exp_ready;
      exp_t               e;
      pfx        = (k == 0) ? "np2_" : "np0_";
      prev_phase = P_RESET;
      in_valid   = '0;
      in_data    = '0;
      out_ready  = 1'b0;
      forever begin
        @(negedge clk);
        cyc++;
        if (phase != prev_phase) begin
          if (prev_phase == P_BP_FILL) check({pfx, "bp_fill_grants"}, WIDTH'(grants), WIDTH'(CREDITS));
          if (prev_phase == P_BP_ONE)  check({pfx, "bp_pop_cycle_grants"}, WIDTH'(grants), WIDTH'(0));
          if (prev_phase == P_BP_HOLD) check({pfx, "bp_after_pop_grants"}, WIDTH'(grants), WIDTH'(1));
          grants     = 0;
          prev_phase = phase;
        end

        for (int r = 0; r < NUM_REQ; r++) in_data[r*WIDTH +: WIDTH] = rand_word();
        case (phase)
          P_SINGLE: begin
            in_valid = (single_left > 0) ? (NUM_REQ'(1) << 2) : '0;
            in_data[2*WIDTH +: WIDTH] = WIDTH'('hA5);
            out_ready = 1'b1;
          end
          P_RR: begin
            in_valid  = '1;
            out_ready = 1'b1;
          end
          P_BP_FILL, P_BP_HOLD: begin
            in_valid  = NUM_REQ'(1);
            out_ready = 1'b0;
          end
          P_BP_ONE: begin
            in_valid  = NUM_REQ'(1);
            out_ready = 1'b1;
          end
          P_BOTH: begin
            in_valid  = NUM_REQ'(1);
            out_ready = (sb.size() >= 4);
          end
          P_RAND: begin
            in_valid  = NUM_REQ'($urandom);
            out_ready = ($urandom_range(0, 3) < (cyc / 500) % 5);
          end
          P_MID_FILL: begin
            in_valid  = (sb.size() < 5) ? NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)) : '0;
            out_ready = 1'b0;
          end
          default: begin
            in_valid  = '0;
            out_ready = (phase == P_DRAIN);
          end
        endcase

        #1;
        blocked   = rst || init_blk;
        outst     = sb.size();
        exp_ready = '0;
        win       = -1;
        if (!rst) check({pfx, "credits"}, WIDTH'(credits), WIDTH'(CREDITS - outst));
        check({pfx, "credits_bound"}, WIDTH'(credits <= CNT_W'(CREDITS)), WIDTH'(1));
        if (!blocked && outst < CREDITS) begin
          for (int i = 1; i <= NUM_REQ; i++) begin
            if (win < 0 && in_valid[(last_grant + i) % NUM_REQ]) win = (last_grant + i) % NUM_REQ;
          end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        check({pfx, "in_ready"}, WIDTH'(in_ready), WIDTH'(exp_ready));
        check({pfx, "busy"}, WIDTH'(busy), WIDTH'(!rst && outst > 0));

        if (win >= 0) begin
          e.id    = ID_W'(win);
          e.data  = in_data[win*WIDTH +: WIDTH];
          e.gcyc  = cyc;
          e.avail = cyc + NP + 1;
          sb.push_back(e);
          last_grant = win;
          grants++;
          if (phase == P_SINGLE) single_left--;
        end
        if (rst) begin
          sb.delete();
          last_grant = NUM_REQ - 1;
          init_blk   = 1'b1;
        end else begin
          init_blk = 1'b0;
        end
      end
    end

    // Monitor: compares the presented head against the scoreboard front.
    initial begin : mon
      string pfx;
      bit    exp_ov;
      pfx = (k == 0) ? "np2_" : "np0_";
      forever begin
        @(negedge clk);
        #2;
        exp_ov = !rst && (sb.size() > 0) && (sb[0].avail <= cyc);
        check({pfx, "out_valid"}, WIDTH'(out_valid), WIDTH'(exp_ov));
        if (out_valid && exp_ov) begin
          check({pfx, "out_id"}, WIDTH'(out_id), WIDTH'(sb[0].id));
          check({pfx, "out_data"}, out_data, sb[0].data);
          if (out_ready) begin
            if (phase == P_SINGLE)
              check({pfx, "single_latency"}, WIDTH'(cyc - sb[0].gcyc), WIDTH'(NP + 1));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic run(input phase_e p, input int n);
    phase = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    run(P_RESET, 3);
    rst = 1'b0;
    run(P_IDLE,     3);
    run(P_SINGLE,   10);
    run(P_DRAIN,    6);
    run(P_RR,       24);
    run(P_DRAIN,    8);
    run(P_BP_FILL,  14);
    run(P_BP_ONE,   1);
    run(P_BP_HOLD,  4);
    run(P_DRAIN,    14);
    run(P_BOTH,     16);
    run(P_DRAIN,    10);
    run(P_RAND,     10000);
    run(P_DRAIN,    20);
    run(P_MID_FILL, 12);
    rst = 1'b1;
    run(P_RESET,    1);
    rst = 1'b0;
    run(P_RR,       8);
    run(P_DRAIN,    12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_credit_arb.md
PIPE_CREDIT_ARB -- requirements
Module: pipe_credit_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..16.
REQ-002 SHALL have parameter WIDTH, default 512: data width per beat.
REQ-003 SHALL have parameter NUM_PIPES, default 2: register stages between grant and output buffer, range 0..8.
REQ-004 SHALL have parameter CREDITS, default 8: output buffer depth, power of two, range 2..64.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_data, input, NUM_REQ*WIDTH: requester r data at bits [r*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, NUM_REQ: per-requester beat valid.
REQ-009 SHALL have port in_ready, output, NUM_REQ: per-requester accept, one-hot or zero.
REQ-010 SHALL have port out_data, output, WIDTH: head-of-buffer data.
REQ-011 SHALL have port out_id, output, $clog2(NUM_REQ): requester index of head beat.
REQ-012 SHALL have port out_valid, output, 1: head beat valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accept.
REQ-014 SHALL have port credits, output, $clog2(CREDITS)+1: free credit count.
REQ-015 SHALL have port busy, output, 1: high while any beat is in pipe stages or buffer.

Function
REQ-016 SHALL transfer requester r when in_valid[r] && in_ready[r]; consumer pop when out_valid && out_ready.
REQ-017 SHALL assert in_ready[r] combinationally only for the round-robin winner among valid requesters, and only when credits > 0.
REQ-018 SHALL search priority starting at last_grant+1 modulo NUM_REQ; last_grant updates only on a transfer.
REQ-019 SHALL keep in_ready low for a requester whose in_valid is low; in_ready SHALL NOT depend on out_ready.
REQ-020 SHALL carry data, requester id and a valid bit through NUM_PIPES register stages, no stalls; a stage with valid low carries no beat.
REQ-021 SHALL, for NUM_PIPES=0, write the granted beat to the buffer in the grant cycle.
REQ-022 SHALL write the pipe output beat into a CREDITS-deep FIFO; beat accepted at cycle t is written at edge t+NUM_PIPES.
REQ-023 SHALL present buffer head registered: out_valid rises the cycle after the write; minimum grant-to-out_valid latency NUM_PIPES+1 cycles.
REQ-024 SHALL preserve grant order at output; no reordering across requesters.
REQ-025 SHALL update credits: -1 on grant, +1 on pop, unchanged when both occur in the same cycle.
REQ-026 SHALL have no combinational credit bypass: pop with credits=0 enables a grant in the following cycle only.
REQ-027 SHALL guarantee by construction that buffer never overflows: in-flight + stored beats <= CREDITS at all times.
REQ-028 SHALL hold out_data/out_id stable while out_valid && !out_ready.
REQ-029 SHALL wrap FIFO pointers modulo CREDITS; full and empty distinguished by an extra pointer bit or occupancy count.
REQ-030 SHALL deassert busy only when all pipe valid bits are low and the buffer is empty.

Reset
REQ-031 SHALL, on rst, clear all pipe valid bits, empty the buffer, set credits=CREDITS, set last_grant=NUM_REQ-1 (requester 0 highest priority).
REQ-032 SHALL drive in_ready=0, out_valid=0, busy=0 during rst and in the first cycle after it; out_data/out_id values are don't-care while out_valid=0.
REQ-033 SHALL discard any in-flight or buffered beat on rst mid-operation; no beat emerges after reset deasserts unless newly granted.

Verification
REQ-034 Single beat: defaults, requester 2 sends 0xA5 once, out_ready=1 -> out_valid at grant+3 cycles, out_data=0xA5, out_id=2, credits 8->7->8.
REQ-035 Round-robin: all four in_valid held high, out_ready=1 -> grant sequence 0,1,2,3,0,... one grant per cycle, out_id in same order.
REQ-036 Backpressure: out_ready=0, requester 0 streaming -> exactly 8 grants, then in_ready=0, credits=0; assert out_ready for one cycle -> exactly one further grant the next cycle.
REQ-037 Simultaneous grant and pop at credits=4 -> credits stays 4; no buffer overflow over 10k random cycles with random in_valid/out_ready.
REQ-038 Reset mid-stream: rst asserted with 5 beats in flight/buffered -> next cycle out_valid=0, credits=8, busy=0; after release requester 0 granted first.
REQ-039 NUM_PIPES=0 build: single beat -> out_valid one cycle after grant, ordering and credit checks as above.
